// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: multi-cycle control FSM that decodes instruction words into datapath enables.
// Optional cycle counter is built when CTRL_CYCLE_COUNT_EN is defined.
module ctrl_sequencer #(
    parameter int IW        = 9,
    parameter int OPW       = 3,
    parameter int TSW       = 2,
    parameter int MEM_LAT   = 1,
    parameter logic [OPW-1:0] OP_LOAD   = 3'b011,
    parameter logic [OPW-1:0] OP_STORE  = 3'b101,
    parameter logic [OPW-1:0] OP_BRANCH = 3'b110,
    parameter logic [OPW-1:0] OP_JUMP   = 3'b111,
    parameter int CW        = 16
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          Start,
    input  logic          Stall,
    input  logic [IW-1:0] Instruction,
    output logic          PcEn,
    output logic          Jump,
    output logic          BranchEn,
    output logic          RegWrEn,
    output logic          MemWrEn,
    output logic          LoadInst,
    output logic [TSW-1:0] TargSel,
    output logic          Ack,
    output logic          Busy,
    output logic [CW-1:0] CycleCount
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXEC    = 2'd1,
        MEMWAIT = 2'd2,
        HALT    = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_INIT =
        (MEM_LAT > 0) ? 4'(MEM_LAT - 1) : 4'd0;

    state_t state, state_n;
    logic [3:0] wcnt, wcnt_n;

    logic [OPW-1:0] op;
    logic halt, is_load, is_store, is_branch, is_jump;
    logic pc_r, jmp_r, br_r, rw_r, mw_r;
    logic start_go;

    assign op        = Instruction[IW-1 -: OPW];
    assign halt      = &Instruction;
    assign is_load   = !halt && (op == OP_LOAD);
    assign is_store  = !halt && (op == OP_STORE);
    assign is_branch = !halt && (op == OP_BRANCH);
    assign is_jump   = !halt && (op == OP_JUMP);

    assign start_go = Start && (state == IDLE || state == HALT);

    // state and load-wait counter registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            wcnt  <= 4'd0;
        end else begin
            state <= state_n;
            wcnt  <= wcnt_n;
        end
    end

    // next-state and decode; stall masks the side-effecting enables
    always_comb begin
        state_n  = state;
        wcnt_n   = wcnt;
        pc_r     = 1'b0;
        jmp_r    = 1'b0;
        br_r     = 1'b0;
        rw_r     = 1'b0;
        mw_r     = 1'b0;
        LoadInst = 1'b0;
        TargSel  = '0;
        Ack      = 1'b0;
        Busy     = 1'b0;
        unique case (state)
            IDLE: begin
                if (Start) state_n = EXEC;
            end
            EXEC: begin
                Busy    = 1'b1;
                TargSel = Instruction[IW-OPW-1 -: TSW];
                unique case (1'b1)
                    halt: begin
                        if (!Stall) state_n = HALT;
                    end
                    is_load: begin
                        LoadInst = 1'b1;
                        if (MEM_LAT == 0) begin
                            rw_r = 1'b1;
                            pc_r = 1'b1;
                        end else if (!Stall) begin
                            state_n = MEMWAIT;
                            wcnt_n  = WAIT_INIT;
                        end
                    end
                    is_store: begin
                        mw_r = 1'b1;
                        pc_r = 1'b1;
                    end
                    is_branch: begin
                        br_r = 1'b1;
                        pc_r = 1'b1;
                    end
                    is_jump: begin
                        jmp_r = 1'b1;
                        pc_r  = 1'b1;
                    end
                    default: begin
                        rw_r = 1'b1;
                        pc_r = 1'b1;
                    end
                endcase
            end
            MEMWAIT: begin
                Busy     = 1'b1;
                LoadInst = 1'b1;
                TargSel  = Instruction[IW-OPW-1 -: TSW];
                if (wcnt == 4'd0) begin
                    rw_r = 1'b1;
                    pc_r = 1'b1;
                    if (!Stall) state_n = EXEC;
                end else if (!Stall) begin
                    wcnt_n = wcnt - 4'd1;
                end
            end
            HALT: begin
                Ack = 1'b1;
                if (Start) state_n = EXEC;
            end
            default: state_n = IDLE;
        endcase
        PcEn     = pc_r  && !Stall;
        Jump     = jmp_r && !Stall;
        BranchEn = br_r  && !Stall;
        RegWrEn  = rw_r  && !Stall;
        MemWrEn  = mw_r  && !Stall;
    end

`ifdef CTRL_CYCLE_COUNT_EN
    logic [CW-1:0] cnt;

    // saturating count of unstalled EXEC/MEMWAIT cycles, cleared on start
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt <= '0;
        end else if (start_go) begin
            cnt <= '0;
        end else if (Busy && !Stall && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign CycleCount = cnt;
`else
    logic unused_go;
    assign unused_go  = start_go;
    assign CycleCount = '0;
`endif

endmodule

// File: doc/ctrl_sequencer.md
# ctrl_sequencer

Parametrised multi-cycle control sequencer. It replaces the purely combinational instruction decoder with a state machine that:
- decodes each instruction word into datapath enables;
- stalls the PC for multi-cycle data-memory loads;
- honours an external stall;
- runs a Start/Ack program handshake;
- optionally counts execution cycles.

It sits between instruction memory and the PC / register file / data memory / LUT in the CPU top level.

## Interface
Parameters:
- IW, 9: instruction width.
- OPW, 3: opcode width; the opcode is Instruction[IW-1 -: OPW].
- TSW, 2: target-select width; the field is Instruction[IW-OPW-1 -: TSW].
- MEM_LAT, 1: data-memory read latency in cycles, range 0..15.
- OP_LOAD, 3'b011; OP_STORE, 3'b101; OP_BRANCH, 3'b110; OP_JUMP, 3'b111: opcode encodings, each OPW bits wide.
- CW, 16: cycle-counter width.

Ports:
- Clk, in, 1: clock, rising edge.
- Reset_n, in, 1: asynchronous, active-low reset.
- Start, in, 1: begin a program; sampled in IDLE and HALT.
- Stall, in, 1: freezes the sequencer.
- Instruction, in, IW: current machine word from instruction memory.
- PcEn, out, 1: advance or load the PC this cycle.
- Jump, out, 1; BranchEn, out, 1: PC control.
- RegWrEn, out, 1; MemWrEn, out, 1; LoadInst, out, 1: datapath enables.
- TargSel, out, TSW: LUT select.
- Ack, out, 1: program done.
- Busy, out, 1: high in EXEC and MEMWAIT.
- CycleCount, out, CW: executed-cycle count.

## Operation
- Halt word: Instruction equal to all ones. Halt takes precedence over every opcode match, including OP_JUMP.
- Instruction classes:
  - ALU: any opcode other than LOAD, STORE, BRANCH or JUMP.
  - TargSel is always the TSW field, gated to 0 outside EXEC and MEMWAIT.
- States: IDLE, EXEC, MEMWAIT, HALT. Reset enters IDLE.
- IDLE:
  - All outputs are 0.
  - Start=1 moves to EXEC next cycle and clears CycleCount.
- EXEC, with Stall=0:
  - ALU: RegWrEn=1, PcEn=1.
  - STORE: MemWrEn=1, PcEn=1.
  - BRANCH: BranchEn=1, PcEn=1.
  - JUMP: Jump=1, PcEn=1.
  - LOAD with MEM_LAT=0: LoadInst=1, RegWrEn=1, PcEn=1; stay in EXEC.
  - LOAD with MEM_LAT>0: LoadInst=1, RegWrEn=0, PcEn=0. Move to MEMWAIT and load the wait counter with MEM_LAT-1.
  - Halt: all enables 0; move to HALT.
- MEMWAIT, with Stall=0:
  - LoadInst=1 throughout.
  - Counter non-zero: decrement; RegWrEn=0, PcEn=0.
  - Counter zero: RegWrEn=1, PcEn=1; return to EXEC.
- Stall=1 in EXEC or MEMWAIT:
  - PcEn, RegWrEn, MemWrEn, Jump and BranchEn are forced to 0.
  - LoadInst and TargSel still follow the decode.
  - State and wait counter hold.
- HALT:
  - Ack=1, all enables 0.
  - Start=1 moves to EXEC next cycle: Ack drops and CycleCount clears.
- Start is ignored in EXEC and MEMWAIT.
- Instruction must be held stable by the PC whenever PcEn=0.

## Timing
- Decode outputs are combinational from the registered state, the wait counter and Instruction. There is no added latency.
- The state, wait-counter and CycleCount registers update on the Clk rising edge.
- Reset_n low asynchronously forces IDLE, wait counter 0 and CycleCount 0, so every output reads 0. This holds mid-load and mid-stall.
- ALU, STORE, BRANCH and JUMP: 1 cycle per instruction.
- LOAD: MEM_LAT+1 cycles; the single-cycle case applies when MEM_LAT=0.
- Start-to-first-PcEn: 1 cycle.
- Halt-word-to-Ack: Ack asserts on the first cycle after the halt word is seen in EXEC.

## Configuration
- CTRL_CYCLE_COUNT_EN defined:
  - CycleCount increments on every Clk edge in EXEC or MEMWAIT with Stall=0.
  - It saturates at all ones and holds in IDLE and HALT.
- CTRL_CYCLE_COUNT_EN undefined: no counter register is built and CycleCount is tied to 0.

## Test plan
- Reset: Reset_n=0 asynchronously between edges → all outputs 0 immediately.
  - Release, then Start pulse → Busy=1 next cycle.
- ALU word 9'b000_10_0101 in EXEC → RegWrEn=1, PcEn=1, TargSel=2'b10, MemWrEn=0.
- MEM_LAT=3, load word 9'b011_01_0000:
  - Cycle 1: LoadInst=1, PcEn=0.
  - MEMWAIT cycles 2 and 3: PcEn=0.
  - Cycle 4: RegWrEn=1, PcEn=1; return to EXEC.
- Stall held 2 cycles during a MEMWAIT → the load completes 2 cycles late, with no RegWrEn or PcEn pulse during the stall.
- Word 9'b111111111 → no Jump, Ack=1 next cycle; Start=1 → Ack=0, Busy=1 next cycle.
- With CTRL_CYCLE_COUNT_EN and CW=4: 20 unstalled ALU cycles → CycleCount=15. Without the macro → CycleCount=0.
